// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit bus controllers: FSM encodings,
// default 50 MHz timing constants and register-select encodings.
package lcd_pkg;

    localparam int T_AS_DEF     = 2;
    localparam int T_EH_DEF     = 12;
    localparam int T_GAP_DEF    = 50;
    localparam int POLL_MAX_DEF = 1000;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EHI_H,
        ST_GAP_H,
        ST_EHI_L,
        ST_GAP_L,
        ST_CHECK
    } lcd_state_t;

    typedef enum logic [1:0] {
        NP_IDLE,
        NP_SETUP,
        NP_EHI,
        NP_GAP
    } nib_phase_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_nibble_cycle.sv
// One LCD nibble transfer: optional RS/RW setup, E pulse with the bus sampled
// on its last cycle, then the recovery gap. phase_last marks each phase's final cycle.
module lcd_nibble_cycle
    import lcd_pkg::*;
#(
    parameter int T_AS  = T_AS_DEF,
    parameter int T_EH  = T_EH_DEF,
    parameter int T_GAP = T_GAP_DEF
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       start,
    input  logic       skip_setup,
    input  logic [3:0] sf_d_in,
    output logic       lcd_e,
    output logic [3:0] nibble,
    output logic       phase_last,
    output logic       nib_done
);

    localparam int CNT_W = $clog2(max3(T_AS, T_EH, T_GAP) + 1);
    localparam logic [CNT_W-1:0] AS_LAST  = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] EH_LAST  = CNT_W'(T_EH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(T_GAP - 1);

    nib_phase_t       phase_reg, phase_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             lcd_e_reg;
    logic [3:0]       nibble_reg;

    always_comb begin
        phase_last = 1'b0;
        unique case (phase_reg)
            NP_SETUP: phase_last = (cnt_reg == AS_LAST);
            NP_EHI:   phase_last = (cnt_reg == EH_LAST);
            NP_GAP:   phase_last = (cnt_reg == GAP_LAST);
            default:  phase_last = 1'b0;
        endcase
    end

    // A start on the final gap cycle chains straight into the next nibble.
    always_comb begin
        phase_next = phase_reg;
        cnt_next   = cnt_reg + 1'b1;
        if (start) begin
            phase_next = skip_setup ? NP_EHI : NP_SETUP;
            cnt_next   = '0;
        end else if (phase_reg == NP_IDLE) begin
            cnt_next = '0;
        end else if (phase_last) begin
            cnt_next = '0;
            unique case (phase_reg)
                NP_SETUP: phase_next = NP_EHI;
                NP_EHI:   phase_next = NP_GAP;
                default:  phase_next = NP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            phase_reg  <= NP_IDLE;
            cnt_reg    <= '0;
            lcd_e_reg  <= 1'b0;
            nibble_reg <= '0;
        end else begin
            phase_reg <= phase_next;
            cnt_reg   <= cnt_next;
            lcd_e_reg <= (phase_next == NP_EHI);
            if (phase_reg == NP_EHI && phase_last) begin
                nibble_reg <= sf_d_in;
            end
        end
    end

    assign lcd_e    = lcd_e_reg;
    assign nibble   = nibble_reg;
    assign nib_done = (phase_reg == NP_GAP) && phase_last;

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read controller: busy-flag/address or data reads over the 4-bit bus,
// with optional busy-flag polling, returned through a req/done handshake.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_AS     = T_AS_DEF,
    parameter int T_EH     = T_EH_DEF,
    parameter int T_GAP    = T_GAP_DEF,
    parameter int POLL_MAX = POLL_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       rs_sel,
    input  logic       poll,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       timeout,
    input  logic [3:0] sf_d_in,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       bus_own
);

    localparam int PC_W = $clog2(POLL_MAX + 1);
    localparam logic [PC_W-1:0] POLL_LIMIT = PC_W'(POLL_MAX);

    lcd_state_t      state_reg, state_next;
    logic            rs_reg, rs_next;
    logic            poll_reg, poll_next;
    logic [3:0]      hi_reg, hi_next;
    logic [PC_W-1:0] read_cnt_reg, read_cnt_next, reads_done;
    logic [7:0]      rdata_reg, rdata_next;
    logic            done_reg, done_next;
    logic            timeout_reg, timeout_next;
    logic            own_reg, lcd_rs_reg;

    logic            nib_start, nib_skip, phase_last, nib_done;
    logic [3:0]      nibble;

    lcd_nibble_cycle #(
        .T_AS  (T_AS),
        .T_EH  (T_EH),
        .T_GAP (T_GAP)
    ) u_nibble (
        .clk        (clk),
        .srst       (reset),
        .start      (nib_start),
        .skip_setup (nib_skip),
        .sf_d_in    (sf_d_in),
        .lcd_e      (lcd_e),
        .nibble     (nibble),
        .phase_last (phase_last),
        .nib_done   (nib_done)
    );

    always_comb begin
        state_next    = state_reg;
        rs_next       = rs_reg;
        poll_next     = poll_reg;
        hi_next       = hi_reg;
        read_cnt_next = read_cnt_reg;
        rdata_next    = rdata_reg;
        done_next     = 1'b0;
        timeout_next  = timeout_reg;
        nib_start     = 1'b0;
        nib_skip      = 1'b0;
        reads_done    = read_cnt_reg + 1'b1;
        unique case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    rs_next       = rs_sel;
                    poll_next     = poll && (rs_sel == RS_CMD);
                    read_cnt_next = '0;
                    nib_start     = 1'b1;
                    state_next    = ST_SETUP;
                end
            end
            ST_SETUP: if (phase_last) state_next = ST_EHI_H;
            ST_EHI_H: if (phase_last) state_next = ST_GAP_H;
            ST_GAP_H: begin
                if (nib_done) begin
                    hi_next    = nibble;
                    nib_start  = 1'b1;
                    nib_skip   = 1'b1;
                    state_next = ST_EHI_L;
                end
            end
            ST_EHI_L: if (phase_last) state_next = ST_GAP_L;
            ST_GAP_L: if (nib_done) state_next = ST_CHECK;
            ST_CHECK: begin
                // reads_done includes the read just finished, so a timeout
                // lands after exactly POLL_MAX reads.
                if (poll_reg && hi_reg[3] && (reads_done < POLL_LIMIT)) begin
                    read_cnt_next = reads_done;
                    nib_start     = 1'b1;
                    state_next    = ST_SETUP;
                end else begin
                    rdata_next   = {hi_reg, nibble};
                    done_next    = 1'b1;
                    timeout_next = poll_reg && hi_reg[3];
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            rs_reg       <= RS_CMD;
            poll_reg     <= 1'b0;
            hi_reg       <= '0;
            read_cnt_reg <= '0;
            rdata_reg    <= '0;
            done_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            own_reg      <= 1'b0;
            lcd_rs_reg   <= RS_CMD;
        end else begin
            state_reg    <= state_next;
            rs_reg       <= rs_next;
            poll_reg     <= poll_next;
            hi_reg       <= hi_next;
            read_cnt_reg <= read_cnt_next;
            rdata_reg    <= rdata_next;
            done_reg     <= done_next;
            timeout_reg  <= timeout_next;
            own_reg      <= (state_next != ST_IDLE);
            lcd_rs_reg   <= (state_next != ST_IDLE) ? rs_next : RS_CMD;
        end
    end

    assign busy    = own_reg;
    assign bus_own = own_reg;
    assign lcd_rw  = own_reg;
    assign lcd_rs  = lcd_rs_reg;
    assign done    = done_reg;
    assign rdata   = rdata_reg;
    assign timeout = timeout_reg;

endmodule
